// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor-side emulator: validates trigger pulses and answers with a distance-coded echo.
// Optional echo-width jitter from a 16-bit LFSR is built only when ECHO_JITTER_EN is defined.
module ultrasonic_echo_responder #(
    parameter int unsigned TRIG_MIN_CYC = 500,
    parameter int unsigned DELAY_CYC    = 25000,
    parameter int unsigned CYC_PER_CM   = 2900,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned TIMEOUT_CYC  = 1900000,
    parameter int unsigned HOLDOFF_CYC  = 500000
`ifdef ECHO_JITTER_EN
    ,
    parameter int unsigned JITTER_CYC   = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic [7:0] runt_cnt
);

    typedef enum logic [2:0] {StIdle, StTrig, StBurst, StEcho, StHold} state_e;

    state_e      state_q;
    logic        trig_m;
    logic        trig_s;
    logic [31:0] cnt_q;
    logic [31:0] width_q;
    logic [31:0] dist_w;
    logic [31:0] base_w;
    logic [31:0] echo_w;
    logic        accept;

    // 2-FF synchronizer; the raw trigger is asynchronous to clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
        end
    end

    assign accept = (state_q == StTrig) && !trig_s && (cnt_q >= TRIG_MIN_CYC);
    assign dist_w = 32'(dist_cm);
    assign base_w = ((dist_w == 32'd0) || (dist_w > MAX_CM)) ? TIMEOUT_CYC
                                                              : dist_w * CYC_PER_CM;

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr_q;

    // x^16 + x^14 + x^13 + x^11 + 1, advanced once per accepted trigger
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign echo_w = base_w + (32'(lfsr_q) % JITTER_CYC);
`else
    assign echo_w = base_w;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 32'd0;
            width_q  <= 32'd0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            runt_cnt <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trig_s) begin
                        state_q <= StTrig;
                        cnt_q   <= 32'd1;
                    end
                end
                StTrig: begin
                    if (trig_s) begin
                        // saturate so a stuck-high trigger never wraps into a runt
                        if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
                    end else if (accept) begin
                        state_q <= StBurst;
                        cnt_q   <= 32'd0;
                        width_q <= echo_w;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        cnt_q   <= 32'd0;
                        if (runt_cnt != 8'hFF) runt_cnt <= runt_cnt + 8'd1;
                    end
                end
                StBurst: begin
                    if (cnt_q == DELAY_CYC - 32'd1) begin
                        state_q <= StEcho;
                        cnt_q   <= 32'd0;
                        echo    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StEcho: begin
                    if (cnt_q == width_q - 32'd1) begin
                        state_q <= StHold;
                        cnt_q   <= 32'd0;
                        echo    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == HOLDOFF_CYC - 32'd1) begin
                        state_q <= StIdle;
                        cnt_q   <= 32'd0;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 32'd0;
                    echo    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder: expected echo widths are queued at stimulus time.
// Define ECHO_JITTER_EN to also exercise the jittered-width scenario.
module tb_ultrasonic_echo_responder;

    localparam int unsigned HOLD = 100;
    localparam int unsigned LAT  = 23;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] dist_cm = 9'd0;
    logic       echo;
    logic       busy;
    logic [7:0] runt_cnt;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int rises = 0;

    always #5 clk = ~clk;
    always @(posedge echo) rises++;

    ultrasonic_echo_responder #(
        .TRIG_MIN_CYC(5),
        .DELAY_CYC   (20),
        .CYC_PER_CM  (10),
        .MAX_CM      (400),
        .TIMEOUT_CYC (5000),
        .HOLDOFF_CYC (HOLD)
`ifdef ECHO_JITTER_EN
        ,
        .JITTER_CYC  (8)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .dist_cm (dist_cm),
        .echo    (echo),
        .busy    (busy),
        .runt_cnt(runt_cnt)
    );

    task automatic pulse_trigger(input int n);
        @(negedge clk);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
    endtask

    // Latency is counted in edges from the first edge that samples trigger low.
    task automatic run_echo(output int lat, output int w, output int h, output bit ok);
        ok = 1'b1; lat = 0; w = 0; h = 0;
        while (!echo && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        if (!echo) begin ok = 1'b0; return; end
        w = 1;
        while (echo && w < 20000) begin
            @(negedge clk);
            if (echo) w++;
        end
        if (echo) begin ok = 1'b0; return; end
        while (busy && h < 20000) begin
            @(negedge clk);
            h++;
        end
        if (busy) ok = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) begin failures++; $display("FAIL reset_echo: got %b expected 0", echo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (runt_cnt !== 8'd0) begin failures++; $display("FAIL reset_runt: got %0d expected 0", runt_cnt); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, w, h, exp_w; bit ok;
        dist_cm = 9'd12;
        exp_q.push_back(12 * 10);
        pulse_trigger(6);
        run_echo(lat, w, h, ok);
        exp_w = exp_q.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got ok=%0d expected 1", ok); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (w != exp_w) begin failures++; $display("FAIL basic_width: got %0d expected %0d", w, exp_w); end
        checks++; if (h != HOLD) begin failures++; $display("FAIL basic_holdoff: got %0d expected %0d", h, HOLD); end
    endtask

    task automatic test_runt();
        int r0; bit seen;
        r0 = rises; seen = 1'b0;
        pulse_trigger(4);
        repeat (60) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checks++; if (rises != r0) begin failures++; $display("FAIL runt_echo: got %0d rises expected %0d", rises, r0); end
        checks++; if (seen) begin failures++; $display("FAIL runt_busy: got busy=1 expected 0"); end
        checks++; if (runt_cnt !== 8'd1) begin failures++; $display("FAIL runt_count: got %0d expected 1", runt_cnt); end
    endtask

    task automatic test_no_object();
        int lat, w, h, exp_w; bit ok;
        int dists[2] = '{0, 401};
        foreach (dists[i]) begin
            dist_cm = 9'(dists[i]);
            exp_q.push_back(5000);
            pulse_trigger(6);
            run_echo(lat, w, h, ok);
            exp_w = exp_q.pop_front();
            checks++; if (!ok || w != exp_w) begin failures++; $display("FAIL no_object_width d=%0d: got %0d ok=%0d expected %0d", dists[i], w, ok, exp_w); end
        end
    endtask

    task automatic test_ignored_retrigger();
        int r0, n, w, exp_w;
        r0 = rises;
        dist_cm = 9'd5;
        exp_q.push_back(50);
        pulse_trigger(6);
        n = 0;
        while (!echo && n < 1000) begin @(negedge clk); n++; end
        w = echo ? 1 : 0;
        trigger = 1'b1;
        dist_cm = 9'd300;
        while (echo && w < 1000) begin
            @(negedge clk);
            if (w == 7) trigger = 1'b0;
            if (echo) w++;
        end
        trigger = 1'b0;
        n = 0;
        while (busy && n < 1000) begin @(negedge clk); n++; end
        repeat (200) @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++; if (w != exp_w) begin failures++; $display("FAIL ignored_width: got %0d expected %0d", w, exp_w); end
        checks++; if (rises != r0 + 1) begin failures++; $display("FAIL ignored_single: got %0d rises expected %0d", rises - r0, 1); end
        checks++; if (runt_cnt !== 8'd1) begin failures++; $display("FAIL ignored_runt: got %0d expected 1", runt_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_echo();
        int lat, w, h, n, exp_w; bit ok;
        dist_cm = 9'd7;
        pulse_trigger(6);
        n = 0;
        while (!echo && n < 1000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++; if (echo !== 1'b1) begin failures++; $display("FAIL midreset_pre: got echo=%b expected 1", echo); end
        reset = 1'b0;
        #1;
        checks++; if (echo !== 1'b0) begin failures++; $display("FAIL midreset_echo: got %b expected 0", echo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (runt_cnt !== 8'd0) begin failures++; $display("FAIL midreset_runt: got %0d expected 0", runt_cnt); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) begin failures++; $display("FAIL midreset_resume: got echo=%b expected 0", echo); end
        dist_cm = 9'd1;
        exp_q.push_back(10);
        pulse_trigger(6);
        run_echo(lat, w, h, ok);
        exp_w = exp_q.pop_front();
        checks++; if (!ok || w != exp_w) begin failures++; $display("FAIL midreset_width: got %0d ok=%0d expected %0d", w, ok, exp_w); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL midreset_latency: got %0d expected %0d", lat, LAT); end
    endtask

`ifdef ECHO_JITTER_EN
    task automatic test_jitter();
        int lat, w, h; bit ok;
        int first[4];
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                dist_cm = 9'd10;
                pulse_trigger(6);
                run_echo(lat, w, h, ok);
                checks++; if (!ok || w < 100 || w > 107) begin failures++; $display("FAIL jitter_range[%0d]: got %0d expected 100..107", i, w); end
                if (pass == 0) first[i] = w;
                else begin
                    checks++; if (w != first[i]) begin failures++; $display("FAIL jitter_repeat[%0d]: got %0d expected %0d", i, w, first[i]); end
                end
            end
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_runt();
        test_no_object();
        test_ignored_retrigger();
        test_reset_mid_echo();
`ifdef ECHO_JITTER_EN
        test_jitter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
